// File: rtl/keypad_scanner.sv
// keypad_scanner
// Active-scan front end for a 3x4 matrix keypad. Drives one column at a time,
// reads the row lines, debounces a single-key press and presents a registered
// one-hot row/column image, a BCD key code, a held level and a press strobe.

module keypad_scanner #(
    parameter int SCAN_DIV = 4,   // cycles each column is driven while scanning (>=1)
    parameter int DEBOUNCE = 8    // identical samples needed to accept press or release (>=2)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [2:0] col_drive,
    output logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [3:0] key_bcd,
    output logic       key_valid,
    output logic       key_held
);

    // Counter widths: the counters only ever hold 0..LIMIT-1, because the
    // terminal sample causes a state change instead of a stored increment.
    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [1:0]         col_q,       col_d;
    logic [SLOT_W-1:0]  slot_q,      slot_d;
    logic [3:0]         cand_row_q,  cand_row_d;
    logic [CNT_W-1:0]   match_q,     match_d;
    logic [CNT_W-1:0]   rel_q,       rel_d;
    logic [2:0]         col_drive_q, col_drive_d;
    logic [3:0]         key_row_q,   key_row_d;
    logic [2:0]         key_col_q,   key_col_d;
    logic [3:0]         key_bcd_q,   key_bcd_d;
    logic               key_valid_q, key_valid_d;
    logic               key_held_q,  key_held_d;

    // Column index to one-hot strobe; the unused index 3 falls back to col1.
    function automatic logic [2:0] col_onehot(input logic [1:0] c);
        logic [2:0] oh;
        case (c)
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b001;
        endcase
        return oh;
    endfunction

    // Next column in the scan rotation, col3 wraps back to col1.
    function automatic logic [1:0] col_next(input logic [1:0] c);
        return (c >= 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    // True when exactly one row line is active; zero or several rows
    // (ghosting, multi-key) are rejected at the scan sample.
    function automatic logic row_single(input logic [3:0] r);
        return (r != 4'd0) && ((r & (r - 4'd1)) == 4'd0);
    endfunction

    // Key code from the one-hot row and the column index.
    // Rows 1-3 carry digits 1-9; row 4 is '*', '0', '#'.
    function automatic logic [3:0] key_code(input logic [3:0] r, input logic [1:0] c);
        logic [3:0] code;
        case (r)
            4'b0001: code = 4'd1 + {2'b00, c};
            4'b0010: code = 4'd4 + {2'b00, c};
            4'b0100: code = 4'd7 + {2'b00, c};
            4'b1000: begin
                case (c)
                    2'd0:    code = 4'hA;
                    2'd1:    code = 4'h0;
                    default: code = 4'hB;
                endcase
            end
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Next-state logic: scan, debounce and hold/release decisions.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        slot_d      = slot_q;
        cand_row_d  = cand_row_q;
        match_d     = match_q;
        rel_d       = rel_q;
        key_row_d   = key_row_q;
        key_col_d   = key_col_q;
        key_bcd_d   = key_bcd_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (slot_q == SLOT_LAST) begin
                    slot_d = '0;
                    if (row_single(row_in)) begin
                        // The scan sample itself is the first match.
                        cand_row_d = row_in;
                        match_d    = CNT_ONE;
                        state_d    = ST_DEBOUNCE;
                    end else begin
                        col_d = col_next(col_q);
                    end
                end else begin
                    slot_d = slot_q + SLOT_ONE;
                end
            end

            ST_DEBOUNCE: begin
                if (row_in == cand_row_q) begin
                    if (match_q == CNT_LAST) begin
                        state_d     = ST_HELD;
                        rel_d       = '0;
                        key_row_d   = cand_row_q;
                        key_col_d   = col_onehot(col_q);
                        key_bcd_d   = key_code(cand_row_q, col_q);
                        key_held_d  = 1'b1;
                        key_valid_d = 1'b1;
                    end else begin
                        match_d = match_q + CNT_ONE;
                    end
                end else begin
                    // Any bounce abandons the candidate and moves on.
                    state_d = ST_SCAN;
                    col_d   = col_next(col_q);
                    slot_d  = '0;
                end
            end

            ST_HELD: begin
                // Only an all-zero row image counts towards release; extra
                // rows while held are ignored and never re-report a press.
                if (row_in == 4'd0) begin
                    if (rel_q == CNT_LAST) begin
                        state_d    = ST_SCAN;
                        col_d      = col_next(col_q);
                        slot_d     = '0;
                        rel_d      = '0;
                        key_row_d  = 4'd0;
                        key_col_d  = 3'd0;
                        key_bcd_d  = 4'd0;
                        key_held_d = 1'b0;
                    end else begin
                        rel_d = rel_q + CNT_ONE;
                    end
                end else begin
                    rel_d = '0;
                end
            end

            default: begin
                state_d = ST_SCAN;
                col_d   = 2'd0;
                slot_d  = '0;
            end
        endcase

        col_drive_d = col_onehot(col_d);
    end

    // State and registered outputs; reset returns to a col1 scan with all key outputs cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            col_q       <= 2'd0;
            slot_q      <= '0;
            cand_row_q  <= 4'd0;
            match_q     <= '0;
            rel_q       <= '0;
            col_drive_q <= 3'b001;
            key_row_q   <= 4'd0;
            key_col_q   <= 3'd0;
            key_bcd_q   <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            slot_q      <= slot_d;
            cand_row_q  <= cand_row_d;
            match_q     <= match_d;
            rel_q       <= rel_d;
            col_drive_q <= col_drive_d;
            key_row_q   <= key_row_d;
            key_col_q   <= key_col_d;
            key_bcd_q   <= key_bcd_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_drive = col_drive_q;
    assign key_row   = key_row_q;
    assign key_col   = key_col_q;
    assign key_bcd   = key_bcd_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a simulated keypad answers the column strobe,
// and a behavioural keypad/scanner model predicts every output each cycle.

module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_in;
    logic [2:0] col_drive;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [3:0] key_bcd;
    logic       key_valid;
    logic       key_held;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_drive (col_drive),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_bcd   (key_bcd),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    int tests = 0;
    int fails = 0;

    // Key index k = row*3 + col (0-based); code per key position.
    int bcd_of [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

    // Reference model: current column, cycles spent on it while scanning,
    // candidate row (-1 none) with its run of equal samples, held key (-1 none)
    // with its run of all-zero samples, and the press pulse.
    int m_col = 0, m_age = 0, m_cand = -1, m_run = 0, m_held = -1, m_zero = 0;
    bit m_valid = 1'b0;

    // Keypad environment.
    logic [11:0] pressed = '0;
    int          bounce_left = 0, bounce_col = 0, zero_left = 0, noise_left = 0;
    logic [3:0]  bounce_pat = 4'd0;
    bit          bounce_ph = 1'b0;

    int         pulses = 0;
    logic [3:0] last_bcd = 4'd0;

    function automatic logic [3:0] env_rows(input int col);
        logic [3:0] r;
        r = 4'd0;
        for (int rr = 0; rr < 4; rr++)
            if (pressed[rr*3 + col]) r[rr] = 1'b1;
        return r;
    endfunction

    task automatic model_update(input logic [3:0] row, input bit rst);
        if (rst) begin
            m_col = 0; m_age = 0; m_cand = -1; m_run = 0;
            m_held = -1; m_zero = 0; m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_held >= 0) begin
                if (row == 4'd0) m_zero++; else m_zero = 0;
                if (m_zero == DEBOUNCE) begin
                    m_held = -1; m_zero = 0; m_col = (m_col + 1) % 3; m_age = 0;
                end
            end else if (m_cand >= 0) begin
                if (row == 4'(1 << m_cand)) begin
                    m_run++;
                    if (m_run == DEBOUNCE) begin
                        m_held = m_cand*3 + m_col; m_valid = 1'b1; m_cand = -1; m_zero = 0;
                    end
                end else begin
                    m_cand = -1; m_col = (m_col + 1) % 3; m_age = 0;
                end
            end else begin
                m_age++;
                if (m_age == SCAN_DIV) begin
                    m_age = 0;
                    if ($countones(row) == 1) begin
                        m_run = 1;
                        for (int i = 0; i < 4; i++) if (row[i]) m_cand = i;
                    end else begin
                        m_col = (m_col + 1) % 3;
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: present rows for the model's column, clock, advance model, compare.
    task automatic tick(input bit rst);
        logic [3:0] r;
        logic [7:0] e_row, e_col, e_bcd;
        r = env_rows(m_col);
        if (zero_left > 0) begin
            r = 4'd0; zero_left--;
        end else if (bounce_left > 0 && m_col == bounce_col) begin
            r = bounce_ph ? bounce_pat : 4'd0; bounce_ph = ~bounce_ph; bounce_left--;
        end else if (noise_left > 0) begin
            r = 4'($urandom_range(0, 15)); noise_left--;
        end
        row_in = r;
        reset  = rst;
        @(posedge clk);
        model_update(r, rst);
        #1;
        e_row = (m_held >= 0) ? 8'(1 << (m_held / 3)) : 8'd0;
        e_col = (m_held >= 0) ? 8'(1 << (m_held % 3)) : 8'd0;
        e_bcd = (m_held >= 0) ? 8'(bcd_of[m_held]) : 8'd0;
        check("col_drive", 8'(col_drive), 8'(1 << m_col));
        check("key_row",   8'(key_row),   e_row);
        check("key_col",   8'(key_col),   e_col);
        check("key_bcd",   8'(key_bcd),   e_bcd);
        check("key_valid", 8'(key_valid), 8'(m_valid));
        check("key_held",  8'(key_held),  8'(m_held >= 0));
        if (key_valid === 1'b1) begin
            pulses++;
            last_bcd = key_bcd;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic wait_held(input string tag, input int limit);
        int n;
        n = 0;
        while (m_held < 0 && n < limit) begin tick(1'b0); n++; end
        check(tag, 8'(m_held >= 0), 8'd1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (m_held >= 0 && n < limit) begin tick(1'b0); n++; end
        check(tag, 8'(m_held < 0), 8'd1);
    endtask

    initial begin
        reset  = 1'b1;
        row_in = 4'd0;

        // Reset state
        tick(1'b1);
        tick(1'b1);
        check("rst_col_drive", 8'(col_drive), 8'h01);
        check("rst_key_bcd",   8'(key_bcd),   8'h00);
        check("rst_key_held",  8'(key_held),  8'h00);
        run(20);

        // Press 5 (row2/col2), hold, release
        pulses = 0; pressed = '0; pressed[4] = 1'b1;
        wait_held("p5_held_timeout", 100);
        check("p5_bcd_now", 8'(key_bcd), 8'h05);
        check("p5_row_now", 8'(key_row), 8'h02);
        check("p5_col_now", 8'(key_col), 8'h02);
        run(15);
        pressed = '0;
        wait_idle("p5_rel_timeout", 100);
        run(5);
        check("p5_pulses", 8'(pulses), 8'd1);
        check("p5_last_bcd", 8'(last_bcd), 8'h05);

        // Bounce on 7: row3 toggles on col1 before settling
        pulses = 0; pressed = '0;
        bounce_col = 0; bounce_pat = 4'b0100; bounce_ph = 1'b1; bounce_left = 5;
        pressed[6] = 1'b1;
        wait_held("b7_held_timeout", 200);
        run(10);
        pressed = '0;
        wait_idle("b7_rel_timeout", 100);
        check("b7_pulses", 8'(pulses), 8'd1);
        check("b7_last_bcd", 8'(last_bcd), 8'h07);

        // Ghost: rows 1 and 3 on col3 simultaneously
        pulses = 0; pressed = '0; pressed[2] = 1'b1; pressed[8] = 1'b1;
        run(40);
        check("ghost_pulses", 8'(pulses), 8'd0);
        check("ghost_held", 8'(key_held), 8'd0);
        pressed = '0;
        run(5);

        // Release glitch while '#' is held
        pulses = 0; pressed = '0; pressed[11] = 1'b1;
        wait_held("hash_held_timeout", 100);
        run(4);
        zero_left = DEBOUNCE - 1;
        run(DEBOUNCE - 1);
        run(20);
        check("glitch_held", 8'(key_held), 8'd1);
        check("glitch_bcd", 8'(key_bcd), 8'h0B);
        check("glitch_pulses", 8'(pulses), 8'd1);
        pressed = '0;
        wait_idle("hash_rel_timeout", 100);

        // '*' then '0' with a full release between
        pulses = 0; pressed = '0; pressed[9] = 1'b1;
        wait_held("star_held_timeout", 100);
        check("star_bcd", 8'(key_bcd), 8'h0A);
        check("star_col", 8'(key_col), 8'h01);
        pressed = '0;
        wait_idle("star_rel_timeout", 100);
        pressed[10] = 1'b1;
        wait_held("zero_held_timeout", 100);
        check("zero_bcd", 8'(key_bcd), 8'h00);
        check("zero_col", 8'(key_col), 8'h02);
        pressed = '0;
        wait_idle("zero_rel_timeout", 100);
        check("seq_pulses", 8'(pulses), 8'd2);

        // One-cycle reset mid-HELD on 9, key still pressed
        pulses = 0; pressed = '0; pressed[8] = 1'b1;
        wait_held("n9_held_timeout", 100);
        run(3);
        tick(1'b1);
        check("n9_rst_held", 8'(key_held), 8'd0);
        check("n9_rst_col", 8'(col_drive), 8'h01);
        check("n9_rst_bcd", 8'(key_bcd), 8'h00);
        wait_held("n9_reheld_timeout", 200);
        check("n9_pulses", 8'(pulses), 8'd2);
        check("n9_last_bcd", 8'(last_bcd), 8'h09);
        pressed = '0;
        wait_idle("n9_rel_timeout", 100);

        // Randomized soak: single keys, multi-key, bounce, noise and idle gaps
        for (int it = 0; it < 150; it++) begin
            int mode, k;
            mode = int'($urandom_range(0, 9));
            pressed = '0;
            k = int'($urandom_range(0, 11));
            if (mode == 0) begin
                pressed = '0;
            end else if (mode == 1) begin
                pressed[k] = 1'b1;
                pressed[int'($urandom_range(0, 11))] = 1'b1;
            end else begin
                pressed[k] = 1'b1;
                if (mode == 2) begin
                    bounce_col = k % 3; bounce_pat = 4'(1 << (k / 3));
                    bounce_ph = 1'b1; bounce_left = int'($urandom_range(1, 9));
                end
                if (mode == 3) noise_left = int'($urandom_range(1, 6));
                if (mode == 4) zero_left = int'($urandom_range(1, DEBOUNCE + 1));
            end
            run(int'($urandom_range(1, 80)));
            if ($urandom_range(0, 2) != 0) begin
                pressed = '0;
                run(int'($urandom_range(1, 30)));
            end
        end
        pressed = '0;
        wait_idle("soak_rel_timeout", 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Active-scan front end for the 3x4 matrix keypad that feeds the safe controller. The block drives the column lines one at a time, reads back the row lines, debounces the result and produces a registered, one-hot row/column image of the pressed key, a BCD key code and a single-cycle press strobe. The row/column image connects directly to the safe's `row1..row4` and `col1..col3` inputs, so the controller sees clean, level-stable key lines instead of raw switch contacts.

## Interface
- `SCAN_DIV`, default 4: cycles each column is driven while scanning (>=1).
- `DEBOUNCE`, default 8: consecutive identical row samples needed to accept a press or a release (>=2).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `row_in`  in  4  raw row sense, active-high, pulled low externally; bit0 = row1.
- `col_drive`  out  3  one-hot column strobe; bit0 = col1.
- `key_row`  out  4  one-hot row of the held key, 0 when no key is held.
- `key_col`  out  3  one-hot column of the held key, 0 when no key is held.
- `key_bcd`  out  4  code of the held key: digits 0-9, `*` = 4'hA, `#` = 4'hB; 0 when idle.
- `key_valid`  out  1  one-cycle pulse on acceptance of a new press.
- `key_held`  out  1  high while a debounced key is held.

## Operation
- Key map: row1 = 1 2 3; row2 = 4 5 6; row3 = 7 8 9; row4 = `*` 0 `#` (col1, col2, col3).
- SCAN: drive column `c`. The slot counter runs 0..SCAN_DIV-1. At slot SCAN_DIV-1, sample `row_in`.
  - If exactly one bit is set, latch the candidate row/column, set the match count to 1 and go to DEBOUNCE.
  - If zero bits or more than one bit is set (ghost or multi-key), advance the column (2 wraps to 0) and reset the slot counter.
- DEBOUNCE: hold `col_drive` on the candidate column and sample every cycle.
  - If the sample equals the candidate pattern, increment the match count.
  - Any mismatch returns to SCAN on the next column, with no outputs changed.
  - When the DEBOUNCE-th matching sample arrives, go to HELD.
- HELD: hold the candidate column.
  - `key_row`, `key_col` and `key_bcd` are registered from the candidate and stay constant.
  - `key_held` = 1; `key_valid` pulses once, in the first HELD cycle only.
  - Release count: increments on each `row_in == 0` sample and clears on any nonzero sample. Extra rows appearing while held are ignored, and no second press is reported.
  - When the DEBOUNCE-th consecutive zero sample arrives, go to SCAN on the next column with slot 0.
- Counter widths are $clog2 of their limit (minimum 1). Counters saturate and never wrap inside a state.

## Timing
- Reset values, visible on the cycle after `reset` is sampled high:
  - `col_drive` = 3'b001, column index 0, slot 0, state SCAN.
  - `key_row` = 0, `key_col` = 0, `key_bcd` = 0.
  - `key_valid` = 0, `key_held` = 0.
- Reset overrides every state. Reset during DEBOUNCE or HELD drops all outputs with no `key_valid` pulse; after deassertion, scanning restarts at col1.
- Press latency: SCAN sample at cycle t counts as match 1. If matches continue, `key_valid`, `key_held` and the key outputs all go high at t+DEBOUNCE.
- Release latency: if the first zero sample is at cycle r and zeros continue, the outputs clear at r+DEBOUNCE. SCAN resumes that same cycle on the next column.
- Worst-case scan-to-sample for an idle column: 3*SCAN_DIV cycles.
- `key_valid` is never high for two consecutive cycles. It is never high while `key_held` was already 1 in the previous cycle.
- All outputs are registered. There are no combinational paths from `row_in` to any output.

## Test plan
- Press `5` (`row_in` = 4'b0010 whenever `col_drive` = 3'b010, stable) -> exactly one `key_valid` pulse, DEBOUNCE cycles after the col2 sample, with `key_bcd` = 5, `key_row` = 4'b0010, `key_col` = 3'b010; outputs clear DEBOUNCE cycles after release.
- Bounce on `7`: `row_in` bit2 toggles every cycle for 5 cycles while col1 is driven, then holds stable -> exactly one pulse, `key_bcd` = 7; no pulse during the toggling.
- Ghost: rows 1 and 3 both high on col3 -> no `key_valid`, `key_held` = 0, column keeps cycling 001 -> 010 -> 100 -> 001.
- Release glitch while `#` is held (row4/col3): `row_in` = 0 for DEBOUNCE-1 cycles, then 4'b1000 again -> `key_held` stays 1, `key_bcd` = 4'hB, no second pulse.
- `*` then `0` pressed in sequence with a full release between -> two pulses, `key_bcd` = 4'hA then 4'h0, `key_col` = 3'b001 then 3'b010.
- Reset asserted for 1 cycle mid-HELD on `9` -> next cycle all outputs 0 and `col_drive` = 3'b001; with `9` still pressed, a fresh pulse follows after rescan.
